reaction_timer: RTL and testbench
=================================

Name: reaction_timer

Overview:
- Consumes the one-cycle start pulse from the button start-pulse stage and runs one reaction-time trial.
- Sequence: waits a pseudo-random delay, lights the LED, then counts milliseconds in BCD until the player presses stop.
- Drives ready back to the start-pulse stage's enable, so a start is only produced when this block can accept it.
- Result feeds the 4-digit 7-segment display driver.

Parameters:
- TICK_DIV, 50000, clk cycles per 1 ms tick (50 MHz clk).
- MIN_WAIT_MS, 1000, fixed part of the random delay, in ms.
- RAND_BITS, 11, number of LFSR bits added to the delay (0..2^RAND_BITS-1 ms).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse from the start-pulse stage.
- stop  in  1  synchronized, debounced stop button, level.
- ready  out  1  high in IDLE and DONE; wired to the start-pulse stage enable.
- led  out  1  "react now" lamp, high only in RUN.
- bcd  out  16  result, 4 BCD digits; [15:12] thousands … [3:0] ones.
- done  out  1  high while in DONE.
- early  out  1  false start: stop pressed during WAIT.
- overflow  out  1  count saturated at 9999 ms.

Behaviour:
- Reset: state=IDLE, ready=1, led=0, bcd=16'h0000, done=0, early=0, overflow=0, LFSR=16'hACE1, tick divider=0, stop_q=0. Reset mid-trial aborts immediately with the same values.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle (free-running, never zero).
- stop_rise = stop & ~stop_q, with stop_q registered every cycle. Only rising edges act, so a held stop never retriggers.
- Tick divider: counts 0..TICK_DIV-1; tick is asserted for one cycle when it equals TICK_DIV-1, then it wraps to 0. It is forced to 0 on the cycle a start is accepted, so the first ms is full length.
- States: IDLE, WAIT, RUN, DONE.
- IDLE (entered only from reset):
  - start=1 -> WAIT.
  - Load wait_ms = MIN_WAIT_MS + LFSR[RAND_BITS-1:0] (zero-extended; width must hold the maximum sum).
  - Clear bcd, early, overflow.
- WAIT: ready=0, led=0.
  - On each tick, wait_ms decrements.
  - tick with wait_ms==1 -> RUN next cycle; led rises exactly wait_ms ticks after accept.
  - stop_rise -> DONE, early=1, bcd=0000.
  - stop_rise beats a simultaneous final tick (early wins).
- RUN: led=1, ready=0.
  - On each tick, bcd increments as 4-digit BCD with ripple carry (9->0 carries to next digit).
  - stop_rise -> DONE, bcd frozen at current value. If stop_rise and tick coincide, no increment.
  - tick while bcd==9999 -> DONE, overflow=1, bcd stays 9999.
- DONE: done=1, ready=1, led=0; bcd/early/overflow held for display.
  - start=1 -> WAIT with the same load/clear actions as IDLE, done falls.
- start outside IDLE/DONE is ignored; the start-pulse stage should not emit it because ready=0.
- stop in IDLE/DONE is ignored.
- All outputs registered; no combinational path from inputs to outputs.

Test Plan (sim params TICK_DIV=4, MIN_WAIT_MS=3, RAND_BITS=2):
- Reset, then hold idle 20 cycles -> ready=1, led=0, done=0, bcd=0000. LFSR is never 0.
- Pulse start while LFSR[1:0]=2'b10 -> led rises exactly 5 ticks (20 cycles) after accept. Pulse stop after 7 further ticks -> DONE, bcd=0007, done=1, ready=1, early=0.
- Pulse start, then assert stop rising edge 2 ticks later (during WAIT) -> DONE, early=1, bcd=0000, led never asserts.
- Hold stop high across the whole trial from before start -> no early; led rises. Count runs until stop falls and re-rises, and bcd equals ticks between led rise and that edge.
- Preload/run to bcd=0099 -> next tick 0100. Run to 9999 with no stop -> next tick gives DONE, overflow=1, bcd=9999.
- Assert rst mid-RUN at bcd=0042 -> next cycle IDLE, all outputs at reset values. Start in DONE re-arms and clears early/overflow/bcd.

Source files
------------

// File: rtl/reaction_timer_if.sv
// Trial handshake and result bus between the start/stop inputs, the reaction timer and the display.
interface reaction_timer_if;
   logic        start;
   logic        stop;
   logic        ready;
   logic        led;
   logic [15:0] bcd;
   logic        done;
   logic        early;
   logic        overflow;

   modport master (
      output start, stop,
      input  ready, led, bcd, done, early, overflow
   );

   modport slave (
      input  start, stop,
      output ready, led, bcd, done, early, overflow
   );
endinterface

// File: rtl/reaction_timer.sv
// Reaction-time trial: random wait, light the LED, then count milliseconds in BCD until stop.
module reaction_timer #(
   parameter int unsigned TICK_DIV    = 50000,
   parameter int unsigned MIN_WAIT_MS = 1000,
   parameter int unsigned RAND_BITS   = 11
) (
   input logic             clk,
   input logic             rst,
   reaction_timer_if.slave bus_io
);

   localparam int unsigned DivW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned WaitW = $clog2(MIN_WAIT_MS + (2 ** RAND_BITS));

   typedef enum logic [1:0] {StIdle, StWait, StRun, StDone} state_e;

   state_e             state_q, state_d;
   logic [15:0]        lfsr_q, lfsr_d;
   logic [DivW-1:0]    div_q, div_d;
   logic [WaitW-1:0]   wait_q, wait_d;
   logic [15:0]        bcd_q, bcd_d;
   logic               early_q, early_d;
   logic               overflow_q, overflow_d;
   logic               stop_q;
   logic               stop_rise;
   logic               tick;
   logic               accept;
   logic [15:0]        bcd_inc;

   assign stop_rise = bus_io.stop & ~stop_q;
   assign tick      = (div_q == DivW'(TICK_DIV - 1));
   assign accept    = bus_io.start & ((state_q == StIdle) | (state_q == StDone));

   // Taps 16,14,13,11; the seed is non-zero so the sequence never locks up.
   assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   // Restart the divider on accept so the first millisecond is full length.
   assign div_d = (accept || tick) ? '0 : div_q + DivW'(1);

   always_comb begin
      logic carry;
      bcd_inc = bcd_q;
      carry   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (bcd_q[4*i +: 4] == 4'd9) begin
               bcd_inc[4*i +: 4] = 4'd0;
            end else begin
               bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
               carry             = 1'b0;
            end
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      bcd_d      = bcd_q;
      early_d    = early_q;
      overflow_d = overflow_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (bus_io.start) begin
               state_d    = StWait;
               wait_d     = WaitW'(MIN_WAIT_MS) + WaitW'(lfsr_q[RAND_BITS-1:0]);
               bcd_d      = '0;
               early_d    = 1'b0;
               overflow_d = 1'b0;
            end
         end
         StWait: begin
            if (stop_rise) begin
               state_d = StDone;
               early_d = 1'b1;
               bcd_d   = '0;
            end else if (tick) begin
               if (wait_q == WaitW'(1)) begin
                  state_d = StRun;
               end else begin
                  wait_d = wait_q - WaitW'(1);
               end
            end
         end
         StRun: begin
            if (stop_rise) begin
               state_d = StDone;
            end else if (tick) begin
               if (bcd_q == 16'h9999) begin
                  state_d    = StDone;
                  overflow_d = 1'b1;
               end else begin
                  bcd_d = bcd_inc;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         lfsr_q     <= 16'hACE1;
         div_q      <= '0;
         wait_q     <= '0;
         bcd_q      <= '0;
         early_q    <= 1'b0;
         overflow_q <= 1'b0;
         stop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         div_q      <= div_d;
         wait_q     <= wait_d;
         bcd_q      <= bcd_d;
         early_q    <= early_d;
         overflow_q <= overflow_d;
         stop_q     <= bus_io.stop;
      end
   end

   assign bus_io.ready    = (state_q == StIdle) | (state_q == StDone);
   assign bus_io.led      = (state_q == StRun);
   assign bus_io.done     = (state_q == StDone);
   assign bus_io.bcd      = bcd_q;
   assign bus_io.early    = early_q;
   assign bus_io.overflow = overflow_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer with a 4-cycle tick and a 3..6 ms random wait.
module tb_reaction_timer;

   logic        clk;
   logic        rst;
   logic [15:0] m_lfsr;
   int          vectors;
   int          miscompares;

   reaction_timer_if bus ();

   reaction_timer #(
      .TICK_DIV    (4),
      .MIN_WAIT_MS (3),
      .RAND_BITS   (2)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   always @(posedge clk) m_lfsr <= rst ? 16'hACE1 : lfsr_next(m_lfsr);

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      int w;
      vectors     = 0;
      miscompares = 0;
      clk         = 1'b0;
      rst         = 1'b1;
      bus.start   = 1'b0;
      bus.stop    = 1'b0;

      // Reset and idle
      step(2);
      chk("rst_ready", bus.ready, 1);
      chk("rst_led", bus.led, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_bcd", bus.bcd, 16'h0000);
      chk("rst_early", bus.early, 0);
      chk("rst_ovf", bus.overflow, 0);
      rst = 1'b0;
      step(20);
      chk("idle_ready", bus.ready, 1);
      chk("idle_led", bus.led, 0);
      chk("idle_done", bus.done, 0);
      chk("idle_bcd", bus.bcd, 16'h0000);
      chk("lfsr_nonzero", {15'd0, dut.lfsr_q != 16'h0}, 1);
      chk("lfsr_seq", dut.lfsr_q, m_lfsr);

      // Normal trial with LFSR[1:0]=2'b10 -> 5 ms wait, stop after 7 ticks
      for (int k = 0; k < 64 && m_lfsr[1:0] != 2'b10; k++) step(1);
      chk("lfsr_pick", {14'd0, dut.lfsr_q[1:0]}, 16'd2);
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      chk("wait_ready", bus.ready, 0);
      chk("wait_led", bus.led, 0);
      step(19);
      chk("led_pre", bus.led, 0);
      step(1);
      chk("led_rise", bus.led, 1);
      step(27);
      chk("run_bcd6", bus.bcd, 16'h0006);
      step(1);
      chk("run_bcd7", bus.bcd, 16'h0007);
      bus.stop = 1'b1;
      step(1);
      chk("stop_done", bus.done, 1);
      chk("stop_ready", bus.ready, 1);
      chk("stop_led", bus.led, 0);
      chk("stop_bcd", bus.bcd, 16'h0007);
      chk("stop_early", bus.early, 0);
      bus.stop = 1'b0;
      step(1);
      bus.stop = 1'b1;
      step(1);
      bus.stop = 1'b0;
      step(8);
      chk("done_stop_ign", bus.done, 1);
      chk("done_bcd_hold", bus.bcd, 16'h0007);

      // False start two ticks into WAIT
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      chk("rearm_done", bus.done, 0);
      chk("rearm_bcd", bus.bcd, 16'h0000);
      step(7);
      bus.stop = 1'b1;
      step(1);
      chk("early_flag", bus.early, 1);
      chk("early_done", bus.done, 1);
      chk("early_bcd", bus.bcd, 16'h0000);
      chk("early_led", bus.led, 0);
      bus.stop = 1'b0;
      step(20);
      chk("early_led_later", bus.led, 0);

      // Stop held from before start: no false start, count until re-press
      bus.stop = 1'b1;
      step(2);
      w = 3 + int'(m_lfsr[1:0]);
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      chk("rearm_early_clr", bus.early, 0);
      step(4 * w - 1);
      chk("held_led_pre", bus.led, 0);
      chk("held_no_early", bus.early, 0);
      step(1);
      chk("held_led_rise", bus.led, 1);
      bus.stop = 1'b0;
      step(13);
      bus.stop = 1'b1;
      step(1);
      chk("held_done", bus.done, 1);
      chk("held_bcd", bus.bcd, 16'h0003);
      chk("held_early", bus.early, 0);
      bus.stop = 1'b0;
      step(1);

      // Long run: digit carries and saturation
      w = 3 + int'(m_lfsr[1:0]);
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      step(4 * w);
      chk("long_led", bus.led, 1);
      step(396);
      chk("bcd_0099", bus.bcd, 16'h0099);
      step(4);
      chk("bcd_0100", bus.bcd, 16'h0100);
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      chk("run_start_ign", bus.led, 1);
      chk("run_start_bcd", bus.bcd, 16'h0100);
      step(3996 - 401);
      chk("bcd_0999", bus.bcd, 16'h0999);
      step(4);
      chk("bcd_1000", bus.bcd, 16'h1000);
      step(39996 - 4000);
      chk("bcd_9999", bus.bcd, 16'h9999);
      chk("sat_led_pre", bus.led, 1);
      chk("sat_ovf_pre", bus.overflow, 0);
      step(4);
      chk("sat_done", bus.done, 1);
      chk("sat_ovf", bus.overflow, 1);
      chk("sat_bcd", bus.bcd, 16'h9999);
      chk("sat_led", bus.led, 0);

      // Re-arm from overflow, then reset mid-run at 0042
      w = 3 + int'(m_lfsr[1:0]);
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      chk("rearm_ovf_clr", bus.overflow, 0);
      chk("rearm_bcd_clr", bus.bcd, 16'h0000);
      step(4 * w);
      chk("r6_led", bus.led, 1);
      step(168);
      chk("r6_bcd42", bus.bcd, 16'h0042);
      rst = 1'b1;
      step(1);
      chk("mid_rst_ready", bus.ready, 1);
      chk("mid_rst_led", bus.led, 0);
      chk("mid_rst_bcd", bus.bcd, 16'h0000);
      chk("mid_rst_done", bus.done, 0);
      chk("mid_rst_early", bus.early, 0);
      chk("mid_rst_ovf", bus.overflow, 0);
      chk("mid_rst_lfsr", dut.lfsr_q, 16'hACE1);
      rst = 1'b0;
      step(8);
      chk("post_rst_led", bus.led, 0);
      chk("post_rst_ready", bus.ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
